// File: rtl/lcd1602_bus_monitor.sv
// lcd1602_bus_monitor
// Passive receiver for the HD44780-style 8-bit write bus of a 16x2 LCD.
// Decodes every enable-qualified transaction into commands or character
// writes, keeps a 2x16 shadow of the visible DDRAM plus the mode flags,
// emulates the busy flag and flags protocol timing violations.
//
// Ports:
//   clk, reset                system clock, asynchronous active-low reset
//   rs, rw, enable, data      raw (asynchronous) LCD bus
//   rd_row, rd_col, rd_char   combinational random-access shadow read port
//   ac                        emulated address counter
//   display_on .. func_2line  display-control, entry-mode and function flags
//   busy                      emulated busy flag
//   cmd_strobe, cmd_code      one-cycle pulse + byte for each decoded command
//   wr_strobe, wr_row/col/char one-cycle pulse + location for visible writes
//   overrun_err, pulse_err, read_err, addr_err  sticky error flags
module lcd1602_bus_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int BUSY_CYCLES   = 2000,
  parameter int CLEAR_CYCLES  = 80000,
  parameter int MIN_EN_CYCLES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic       rd_row,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic       cmd_strobe,
  output logic [7:0] cmd_code,
  output logic       wr_strobe,
  output logic       wr_row,
  output logic [3:0] wr_col,
  output logic [7:0] wr_char,
  output logic       overrun_err,
  output logic       pulse_err,
  output logic       read_err,
  output logic       addr_err
);

  localparam int BUSY_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int BW       = $clog2(BUSY_MAX + 1);
  localparam int EW       = $clog2(MIN_EN_CYCLES + 1);

  localparam logic [BW-1:0] BUSY_LOAD  = BW'(BUSY_CYCLES);
  localparam logic [BW-1:0] CLEAR_LOAD = BW'(CLEAR_CYCLES);
  localparam logic [EW-1:0] EN_MIN     = EW'(MIN_EN_CYCLES);

  // Data writes land in DDRAM until a CGRAM address set diverts them.
  typedef enum logic {
    MODE_DDRAM = 1'b0,
    MODE_CGRAM = 1'b1
  } addr_mode_t;

  // Synchronizer chains
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] rs_sync_q, rs_sync_d;
  logic [SYNC_STAGES-1:0] rw_sync_q, rw_sync_d;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic [7:0]             data_sync_d [SYNC_STAGES];

  // Edge detect, pulse width and captured transaction
  logic          en_prev_q, en_prev_d;
  logic [EW-1:0] en_width_q, en_width_d;
  logic          txn_valid_q, txn_valid_d;
  logic          txn_rs_q, txn_rs_d;
  logic          txn_rw_q, txn_rw_d;
  logic          txn_short_q, txn_short_d;
  logic [7:0]    txn_data_q, txn_data_d;

  // Architectural state
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [6:0]    ac_q, ac_d;
  logic          display_on_q, display_on_d;
  logic          cursor_on_q, cursor_on_d;
  logic          blink_on_q, blink_on_d;
  logic          entry_inc_q, entry_inc_d;
  logic          entry_shift_q, entry_shift_d;
  logic          func_8bit_q, func_8bit_d;
  logic          func_2line_q, func_2line_d;
  addr_mode_t    mode_q, mode_d;
  logic [7:0]    shadow_q [32];
  logic [7:0]    shadow_d [32];

  // Strobes and error flags
  logic       cmd_strobe_q, cmd_strobe_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       wr_row_q, wr_row_d;
  logic [3:0] wr_col_q, wr_col_d;
  logic [7:0] wr_char_q, wr_char_d;
  logic       overrun_err_q, overrun_err_d;
  logic       pulse_err_q, pulse_err_d;
  logic       read_err_q, read_err_d;
  logic       addr_err_q, addr_err_d;

  logic       en_s;
  logic       en_fall;
  logic [6:0] set_addr;
  logic       set_addr_bad;
  logic       ac_visible;

  // Address counter step with the controller's wrap rules. In 2-line mode
  // the two 40-byte lines form one ring; in 1-line mode 0x00-0x4F is a ring.
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up,
                                         input logic two_line);
    logic [6:0] r;
    if (two_line) begin
      if (up) r = (a == 7'h27) ? 7'h40 : ((a == 7'h67) ? 7'h00 : a + 7'd1);
      else    r = (a == 7'h00) ? 7'h67 : ((a == 7'h40) ? 7'h27 : a - 7'd1);
    end else begin
      if (up) r = (a >= 7'h4F) ? 7'h00 : a + 7'd1;
      else    r = (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
    return r;
  endfunction

  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign en_fall  = en_prev_q & ~en_s;
  assign set_addr = txn_data_q[6:0];
  assign set_addr_bad = ((set_addr >= 7'h28) && (set_addr <= 7'h3F)) || (set_addr >= 7'h68);
  assign ac_visible   = (ac_q[5:4] == 2'b00);

  // Front end: rs/rw/data ride the same chain as enable so the fields used
  // come from the very sample that saw enable low. The fall is registered
  // into txn_* once, giving one extra cycle before the effect edge.
  always_comb begin
    en_sync_d[0]   = enable;
    rs_sync_d[0]   = rs;
    rw_sync_d[0]   = rw;
    data_sync_d[0] = data;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      en_sync_d[i]   = en_sync_q[i-1];
      rs_sync_d[i]   = rs_sync_q[i-1];
      rw_sync_d[i]   = rw_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
    en_prev_d = en_s;
    if (en_s) en_width_d = (en_width_q == EN_MIN) ? en_width_q : en_width_q + EW'(1);
    else      en_width_d = '0;
    txn_valid_d = en_fall;
    txn_rs_d    = rs_sync_q[SYNC_STAGES-1];
    txn_rw_d    = rw_sync_q[SYNC_STAGES-1];
    txn_data_d  = data_sync_q[SYNC_STAGES-1];
    txn_short_d = (en_width_q < EN_MIN);
  end

  // Transaction execution. Command decode is by the highest set bit.
  // ac_visible relies on a legal ac: bit6 picks the row, bits 5:4 must be 0.
  always_comb begin
    ac_d          = ac_q;
    display_on_d  = display_on_q;
    cursor_on_d   = cursor_on_q;
    blink_on_d    = blink_on_q;
    entry_inc_d   = entry_inc_q;
    entry_shift_d = entry_shift_q;
    func_8bit_d   = func_8bit_q;
    func_2line_d  = func_2line_q;
    mode_d        = mode_q;
    shadow_d      = shadow_q;
    busy_cnt_d    = (busy_cnt_q != '0) ? busy_cnt_q - BW'(1) : '0;
    cmd_strobe_d  = 1'b0;
    cmd_code_d    = cmd_code_q;
    wr_strobe_d   = 1'b0;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    wr_char_d     = wr_char_q;
    overrun_err_d = overrun_err_q;
    pulse_err_d   = pulse_err_q;
    read_err_d    = read_err_q;
    addr_err_d    = addr_err_q;

    if (txn_valid_q) begin
      if (txn_rw_q) begin
        read_err_d = 1'b1;
      end else begin
        if (txn_short_q) pulse_err_d = 1'b1;
        if (busy_cnt_q != '0) overrun_err_d = 1'b1;
        busy_cnt_d = BUSY_LOAD;
        if (!txn_rs_q) begin
          cmd_strobe_d = |txn_data_q;
          if (|txn_data_q) cmd_code_d = txn_data_q;
          if (txn_data_q[7]) begin
            mode_d = MODE_DDRAM;
            if (set_addr_bad) begin
              addr_err_d = 1'b1;
              ac_d       = '0;
            end else begin
              ac_d = set_addr;
            end
          end else if (txn_data_q[6]) begin
            mode_d = MODE_CGRAM;
          end else if (txn_data_q[5]) begin
            func_8bit_d  = txn_data_q[4];
            func_2line_d = txn_data_q[3];
          end else if (txn_data_q[4]) begin
            // Display shift (bit3=1) has no effect on the shadow.
            if (!txn_data_q[3]) ac_d = step_ac(ac_q, txn_data_q[2], func_2line_q);
          end else if (txn_data_q[3]) begin
            display_on_d = txn_data_q[2];
            cursor_on_d  = txn_data_q[1];
            blink_on_d   = txn_data_q[0];
          end else if (txn_data_q[2]) begin
            entry_inc_d   = txn_data_q[1];
            entry_shift_d = txn_data_q[0];
          end else if (txn_data_q[1]) begin
            ac_d       = '0;
            busy_cnt_d = CLEAR_LOAD;
          end else if (txn_data_q[0]) begin
            for (int i = 0; i < 32; i++) shadow_d[i] = 8'h20;
            ac_d        = '0;
            entry_inc_d = 1'b1;
            busy_cnt_d  = CLEAR_LOAD;
          end
        end else if (mode_q == MODE_DDRAM) begin
          if (ac_visible) begin
            shadow_d[{ac_q[6], ac_q[3:0]}] = txn_data_q;
            wr_strobe_d = 1'b1;
            wr_row_d    = ac_q[6];
            wr_col_d    = ac_q[3:0];
            wr_char_d   = txn_data_q;
          end
          ac_d = step_ac(ac_q, entry_inc_q, func_2line_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync_q     <= '0;
      rs_sync_q     <= '0;
      rw_sync_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      en_prev_q     <= 1'b0;
      en_width_q    <= '0;
      txn_valid_q   <= 1'b0;
      txn_rs_q      <= 1'b0;
      txn_rw_q      <= 1'b0;
      txn_short_q   <= 1'b0;
      txn_data_q    <= '0;
      busy_cnt_q    <= '0;
      ac_q          <= '0;
      display_on_q  <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      entry_inc_q   <= 1'b1;
      entry_shift_q <= 1'b0;
      func_8bit_q   <= 1'b1;
      func_2line_q  <= 1'b0;
      mode_q        <= MODE_DDRAM;
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
      cmd_strobe_q  <= 1'b0;
      cmd_code_q    <= '0;
      wr_strobe_q   <= 1'b0;
      wr_row_q      <= 1'b0;
      wr_col_q      <= '0;
      wr_char_q     <= '0;
      overrun_err_q <= 1'b0;
      pulse_err_q   <= 1'b0;
      read_err_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      en_sync_q     <= en_sync_d;
      rs_sync_q     <= rs_sync_d;
      rw_sync_q     <= rw_sync_d;
      data_sync_q   <= data_sync_d;
      en_prev_q     <= en_prev_d;
      en_width_q    <= en_width_d;
      txn_valid_q   <= txn_valid_d;
      txn_rs_q      <= txn_rs_d;
      txn_rw_q      <= txn_rw_d;
      txn_short_q   <= txn_short_d;
      txn_data_q    <= txn_data_d;
      busy_cnt_q    <= busy_cnt_d;
      ac_q          <= ac_d;
      display_on_q  <= display_on_d;
      cursor_on_q   <= cursor_on_d;
      blink_on_q    <= blink_on_d;
      entry_inc_q   <= entry_inc_d;
      entry_shift_q <= entry_shift_d;
      func_8bit_q   <= func_8bit_d;
      func_2line_q  <= func_2line_d;
      mode_q        <= mode_d;
      shadow_q      <= shadow_d;
      cmd_strobe_q  <= cmd_strobe_d;
      cmd_code_q    <= cmd_code_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_char_q     <= wr_char_d;
      overrun_err_q <= overrun_err_d;
      pulse_err_q   <= pulse_err_d;
      read_err_q    <= read_err_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign rd_char     = shadow_q[{rd_row, rd_col}];
  assign ac          = ac_q;
  assign display_on  = display_on_q;
  assign cursor_on   = cursor_on_q;
  assign blink_on    = blink_on_q;
  assign entry_inc   = entry_inc_q;
  assign entry_shift = entry_shift_q;
  assign func_8bit   = func_8bit_q;
  assign func_2line  = func_2line_q;
  assign busy        = (busy_cnt_q != '0);
  assign cmd_strobe  = cmd_strobe_q;
  assign cmd_code    = cmd_code_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_char     = wr_char_q;
  assign overrun_err = overrun_err_q;
  assign pulse_err   = pulse_err_q;
  assign read_err    = read_err_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// tb_lcd1602_bus_monitor
// Directed plus randomized bus transactions against lcd1602_bus_monitor.
// A behavioural model of the LCD (linear line positions, byte array shadow,
// busy as a cycle window) supplies every expected value.
module tb_lcd1602_bus_monitor;

  localparam int SYNC   = 2;
  localparam int BUSY   = 40;
  localparam int CLEAR  = 200;
  localparam int MIN_EN = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       rs, rw, enable;
  logic [7:0] data;
  logic       rd_row;
  logic [3:0] rd_col;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       display_on, cursor_on, blink_on, entry_inc, entry_shift;
  logic       func_8bit, func_2line, busy;
  logic       cmd_strobe, wr_strobe, wr_row;
  logic [7:0] cmd_code, wr_char;
  logic [3:0] wr_col;
  logic       overrun_err, pulse_err, read_err, addr_err;

  int cyc = 0;
  int check_count = 0;
  int pass_count = 0;
  int fail_count = 0;

  // Reference model state
  int         m_ac;
  bit         m_disp, m_cur, m_blink, m_inc, m_shift, m_8bit, m_2line, m_cg;
  bit         m_over, m_pulse, m_read, m_addr;
  logic [7:0] m_shadow [32];
  int         load_edge, load_len;
  bit         exp_cmd, exp_wr, exp_row;
  int         exp_col;
  logic [7:0] exp_char;

  lcd1602_bus_monitor #(
    .SYNC_STAGES(SYNC), .BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR), .MIN_EN_CYCLES(MIN_EN)
  ) dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
    .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char), .ac(ac),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift),
    .func_8bit(func_8bit), .func_2line(func_2line), .busy(busy),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code),
    .wr_strobe(wr_strobe), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .overrun_err(overrun_err), .pulse_err(pulse_err), .read_err(read_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(80000 * 10);
    $display("[TB] FAIL watchdog: observed no finish, required finish within 80000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_count++;
    assert (obs === expv) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_ac = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_shift = 0;
    m_8bit = 1; m_2line = 0; m_cg = 0;
    m_over = 0; m_pulse = 0; m_read = 0; m_addr = 0;
    load_edge = 0; load_len = 0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
  endtask

  function automatic bit busyAt(input int x);
    return (load_len > 0) && ((x - load_edge) < load_len);
  endfunction

  // Two-line mode: both 40-character lines form one 80-position ring.
  function automatic int nextAddr(input int a, input bit up, input bit two_line);
    int pos;
    if (two_line) begin
      pos = (a >= 64) ? (a - 64 + 40) : a;
      pos = up ? (pos + 1) % 80 : (pos + 79) % 80;
      return (pos < 40) ? pos : (pos - 40 + 64);
    end
    return up ? (a + 1) % 80 : (a + 79) % 80;
  endfunction

  task automatic modelApply(input bit i_rs, input bit i_rw, input logic [7:0] d,
                            input int hi, input int eff);
    int a;
    exp_cmd = 0; exp_wr = 0; exp_row = 0; exp_col = 0; exp_char = 8'h00;
    if (i_rw) begin
      m_read = 1;
      return;
    end
    if (hi < MIN_EN) m_pulse = 1;
    if (busyAt(eff - 1)) m_over = 1;
    load_edge = eff;
    load_len  = BUSY;
    if (!i_rs) begin
      exp_cmd = (d != 8'h00);
      if (d >= 8'h80) begin
        a = int'(d) - 128;
        m_cg = 0;
        if ((a >= 40 && a < 64) || a >= 104) begin
          m_addr = 1;
          m_ac = 0;
        end else m_ac = a;
      end else if (d >= 8'h40) m_cg = 1;
      else if (d >= 8'h20) begin
        m_8bit = d[4]; m_2line = d[3];
      end else if (d >= 8'h10) begin
        if (!d[3]) m_ac = nextAddr(m_ac, d[2], m_2line);
      end else if (d >= 8'h08) begin
        m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
      end else if (d >= 8'h04) begin
        m_inc = d[1]; m_shift = d[0];
      end else if (d >= 8'h02) begin
        m_ac = 0; load_len = CLEAR;
      end else if (d == 8'h01) begin
        for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
        m_ac = 0; m_inc = 1; load_len = CLEAR;
      end
    end else if (!m_cg) begin
      if (m_ac < 16) begin
        exp_wr = 1; exp_row = 0; exp_col = m_ac;
      end else if (m_ac >= 64 && m_ac < 80) begin
        exp_wr = 1; exp_row = 1; exp_col = m_ac - 64;
      end
      if (exp_wr) begin
        exp_char = d;
        m_shadow[exp_row * 16 + exp_col] = d;
      end
      m_ac = nextAddr(m_ac, m_inc, m_2line);
    end
  endtask

  task automatic checkState();
    checkOutput("ac", 32'(ac), 32'(m_ac));
    checkOutput("display_on", 32'(display_on), 32'(m_disp));
    checkOutput("cursor_on", 32'(cursor_on), 32'(m_cur));
    checkOutput("blink_on", 32'(blink_on), 32'(m_blink));
    checkOutput("entry_inc", 32'(entry_inc), 32'(m_inc));
    checkOutput("entry_shift", 32'(entry_shift), 32'(m_shift));
    checkOutput("func_8bit", 32'(func_8bit), 32'(m_8bit));
    checkOutput("func_2line", 32'(func_2line), 32'(m_2line));
    checkOutput("busy", 32'(busy), 32'(busyAt(cyc)));
    checkOutput("overrun_err", 32'(overrun_err), 32'(m_over));
    checkOutput("pulse_err", 32'(pulse_err), 32'(m_pulse));
    checkOutput("read_err", 32'(read_err), 32'(m_read));
    checkOutput("addr_err", 32'(addr_err), 32'(m_addr));
    rd_row = 1'($urandom_range(0, 1));
    rd_col = 4'($urandom_range(0, 15));
    #1;
    checkOutput("rd_char", 32'(rd_char), 32'(m_shadow[rd_row * 16 + rd_col]));
  endtask

  task automatic sweepCells();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        rd_row = 1'(r);
        rd_col = 4'(c);
        #1;
        checkOutput("rd_char_sweep", 32'(rd_char), 32'(m_shadow[r * 16 + c]));
      end
    end
  endtask

  // Called right after enable was driven low at a falling clock edge.
  task automatic finishTxn(input bit i_rs, input bit i_rw, input logic [7:0] d,
                           input int hi, input int gap);
    repeat (SYNC + 1) @(posedge clk);
    #1;
    checkOutput("cmd_strobe_early", 32'(cmd_strobe), 32'd0);
    checkOutput("wr_strobe_early", 32'(wr_strobe), 32'd0);
    @(posedge clk);
    #1;
    modelApply(i_rs, i_rw, d, hi, cyc);
    checkOutput("cmd_strobe", 32'(cmd_strobe), 32'(exp_cmd));
    if (exp_cmd) checkOutput("cmd_code", 32'(cmd_code), 32'(d));
    checkOutput("wr_strobe", 32'(wr_strobe), 32'(exp_wr));
    if (exp_wr) begin
      checkOutput("wr_row", 32'(wr_row), 32'(exp_row));
      checkOutput("wr_col", 32'(wr_col), 32'(exp_col));
      checkOutput("wr_char", 32'(wr_char), 32'(exp_char));
    end
    checkState();
    @(posedge clk);
    #1;
    checkOutput("cmd_strobe_width", 32'(cmd_strobe), 32'd0);
    checkOutput("wr_strobe_width", 32'(wr_strobe), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit i_rs, input bit i_rw, input logic [7:0] d,
                               input int hi, input int gap);
    @(negedge clk);
    rs = i_rs; rw = i_rw; data = d; enable = 1'b1;
    repeat (hi) @(negedge clk);
    enable = 1'b0;
    finishTxn(i_rs, i_rw, d, hi, gap);
  endtask

  initial begin
    bit         r_rs, r_rw;
    logic [7:0] r_d;
    int         r_hi, r_gap;

    reset = 1'b0; rs = 0; rw = 0; enable = 0; data = 8'h00; rd_row = 0; rd_col = 0;
    modelReset();
    repeat (5) @(negedge clk);
    checkState();
    sweepCells();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkState();

    // Power-up initialisation sequence
    applyStimulus(0, 0, 8'h38, 14, 50);
    applyStimulus(0, 0, 8'h0C, 14, 50);
    applyStimulus(0, 0, 8'h06, 14, 50);
    applyStimulus(0, 0, 8'h01, 14, 210);
    checkOutput("init_func_2line", 32'(func_2line), 32'd1);
    sweepCells();

    // "Hi" at the home position
    applyStimulus(0, 0, 8'h80, 14, 50);
    applyStimulus(1, 0, 8'h48, 14, 50);
    applyStimulus(1, 0, 8'h69, 14, 50);
    rd_row = 1'b0; rd_col = 4'd1;
    #1;
    checkOutput("rd_char_0_1", 32'(rd_char), 32'h69);
    checkOutput("ac_after_hi", 32'(ac), 32'h02);

    // End of line 0 wraps into line 1
    applyStimulus(0, 0, 8'hA7, 14, 50);
    applyStimulus(1, 0, 8'h41, 14, 50);
    checkOutput("ac_wrap_40", 32'(ac), 32'h40);
    applyStimulus(1, 0, 8'h41, 14, 50);
    checkOutput("ac_41", 32'(ac), 32'h41);

    // Decrementing write at 0x00 wraps to 0x67
    applyStimulus(0, 0, 8'h04, 14, 50);
    applyStimulus(0, 0, 8'h80, 14, 50);
    applyStimulus(1, 0, 8'h42, 14, 50);
    checkOutput("ac_wrap_67", 32'(ac), 32'h67);
    applyStimulus(0, 0, 8'h06, 14, 50);

    // One-line ring 0x4F <-> 0x00
    applyStimulus(0, 0, 8'h30, 14, 50);
    applyStimulus(0, 0, 8'hCF, 14, 50);
    applyStimulus(1, 0, 8'h55, 14, 50);
    applyStimulus(0, 0, 8'h04, 14, 50);
    applyStimulus(1, 0, 8'h56, 14, 50);
    applyStimulus(0, 0, 8'h06, 14, 50);
    applyStimulus(0, 0, 8'h38, 14, 50);

    // CGRAM diversion, then cursor/display shifts
    applyStimulus(0, 0, 8'h40, 14, 50);
    applyStimulus(1, 0, 8'h77, 14, 50);
    applyStimulus(0, 0, 8'h85, 14, 50);
    applyStimulus(0, 0, 8'h14, 14, 50);
    applyStimulus(0, 0, 8'h10, 14, 50);
    applyStimulus(0, 0, 8'h18, 14, 50);

    // Protocol errors
    applyStimulus(0, 0, 8'h01, 14, 86);
    applyStimulus(0, 0, 8'h0E, 14, 250);
    checkOutput("overrun_set", 32'(overrun_err), 32'd1);
    applyStimulus(0, 0, 8'h0C, 4, 60);
    checkOutput("pulse_set", 32'(pulse_err), 32'd1);
    applyStimulus(1, 1, 8'h00, 14, 60);
    checkOutput("read_set", 32'(read_err), 32'd1);
    applyStimulus(0, 0, 8'hB0, 14, 60);
    checkOutput("addr_set", 32'(addr_err), 32'd1);
    checkOutput("addr_ac", 32'(ac), 32'd0);

    // Randomized traffic, staying in 2-line mode
    for (int n = 0; n < 150; n++) begin
      r_rw  = ($urandom_range(0, 19) == 0);
      r_rs  = ($urandom_range(0, 9) < 6);
      r_hi  = $urandom_range(4, 20);
      r_gap = $urandom_range(2, 60);
      if (r_rs) r_d = 8'($urandom_range(8'h20, 8'h7E));
      else begin
        r_d = 8'($urandom_range(1, 255));
        if (r_d >= 8'h20 && r_d < 8'h40) r_d[3] = 1'b1;
      end
      applyStimulus(r_rs, r_rw, r_d, r_hi, r_gap);
    end
    sweepCells();

    // Reset in the middle of an enable-high pulse
    @(negedge clk);
    rs = 0; rw = 0; data = 8'h0F; enable = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    modelReset();
    #1;
    checkState();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkState();
    checkOutput("no_txn_after_reset", 32'(cmd_strobe), 32'd0);
    repeat (18) @(negedge clk);
    enable = 1'b0;
    finishTxn(0, 0, 8'h0F, 19, 10);
    sweepCells();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
